// File: rtl/aes_pkg.sv
// Shared constants, types and GF(2^8) byte arithmetic for the AES-256 inverse cipher.
// Blocks and words are big-endian by byte: byte 0 of a block lives in bits [127:120].
package aes_pkg;

  localparam int KEY_BW = 256;
  localparam int TXT_BW = 128;
  localparam int NR     = 14;

  // RCON[i] for i = 1..7; index 0 is unused.
  localparam logic [7:0][7:0] RCON = {8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00};

  typedef enum logic [1:0] {IDLE = 2'd0, KEXP = 2'd1, ROUND = 2'd2} state_e;

  // Byte n of a block sits at index 15-n.
  typedef logic [15:0][7:0] blk_t;

  function automatic logic [7:0] gf_mul2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = gf_mul2(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse and conveniently maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (i != 0) r = gf_mul(r, a);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] x;
    x = gf_inv(b);
    return x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return gf_inv(rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Row r rotates right by r columns.
  function automatic blk_t inv_shift_rows(input blk_t s);
    blk_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[15 - (4 * c + r)] = s[15 - (4 * ((c - r + 4) % 4) + r)];
    return o;
  endfunction

  function automatic blk_t inv_mix_columns(input blk_t s);
    blk_t o;
    logic [3:0][7:0] m9, mb, md, me;
    logic [7:0] x1, x2, x4, x8;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        x1 = s[15 - (4 * c + r)];
        x2 = gf_mul2(x1);
        x4 = gf_mul2(x2);
        x8 = gf_mul2(x4);
        m9[r] = x8 ^ x1;
        mb[r] = x8 ^ x2 ^ x1;
        md[r] = x8 ^ x4 ^ x1;
        me[r] = x8 ^ x4 ^ x2;
      end
      o[15 - 4 * c]       = me[0] ^ mb[1] ^ md[2] ^ m9[3];
      o[15 - (4 * c + 1)] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
      o[15 - (4 * c + 2)] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
      o[15 - (4 * c + 3)] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless this is the final round.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [TXT_BW-1:0] state,
  input  logic [TXT_BW-1:0] rk,
  input  logic              last,
  output logic [TXT_BW-1:0] nxt
);

  blk_t sr, rkb, t;

  assign sr  = inv_shift_rows(state);
  assign rkb = rk;

  for (genvar i = 0; i < 16; i++) begin : g_lane
    assign t[i] = inv_sbox(sr[i]) ^ rkb[i];
  end

  assign nxt = last ? t : inv_mix_columns(t);

endmodule

// File: rtl/aes256_decrypt.sv
// Iterative AES-256 decryptor: 13 key-expansion cycles, then 14 inverse rounds.
// Optional AES_KEY_CACHE_EN skips key expansion when the key repeats.
module aes256_decrypt
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [KEY_BW-1:0] key,
  input  logic [TXT_BW-1:0] word,
  output logic [TXT_BW-1:0] result,
  output logic              done,
  output logic              busy
);

  state_e st, st_nxt;
  logic [3:0] cnt;
  logic [TXT_BW-1:0] rk [0:NR];
  logic [TXT_BW-1:0] blk, rk_cur, rk_p1, rk_p2, rk_new, rnd_out;
  logic [31:0] tw, w0, w1, w2, w3;
  logic hit;

  // cnt is the round-key index being produced (KEXP) or consumed (ROUND).
  always_comb begin
    rk_cur = '0;
    rk_p1  = '0;
    rk_p2  = '0;
    for (int k = 0; k <= NR; k++) begin
      if (k == int'(cnt))     rk_cur = rk[k];
      if (k + 1 == int'(cnt)) rk_p1  = rk[k];
      if (k + 2 == int'(cnt)) rk_p2  = rk[k];
    end
  end

  // Even k starts an 8-word group (RotWord+SubWord+Rcon); odd k is the mid-group SubWord.
  always_comb begin
    tw = rk_p1[31:0];
    if (cnt[0]) tw = sub_word(tw);
    else        tw = sub_word({tw[23:0], tw[31:24]}) ^ {RCON[cnt[3:1]], 24'h0};
    w0 = rk_p2[127:96] ^ tw;
    w1 = rk_p2[95:64]  ^ w0;
    w2 = rk_p2[63:32]  ^ w1;
    w3 = rk_p2[31:0]   ^ w2;
    rk_new = {w0, w1, w2, w3};
  end

  aes_inv_round u_round (
    .state (blk),
    .rk    (rk_cur),
    .last  (cnt == 4'd0),
    .nxt   (rnd_out)
  );

`ifdef AES_KEY_CACHE_EN
  logic [KEY_BW-1:0] cache_key;
  logic              cache_vld;

  assign hit = cache_vld && (key == cache_key);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_key <= '0;
      cache_vld <= 1'b0;
    end else if (st == KEXP && cnt == 4'(NR)) begin
      cache_key <= {rk[0], rk[1]};
      cache_vld <= 1'b1;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else     st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:    if (enable) st_nxt = hit ? ROUND : KEXP;
      KEXP:    if (cnt == 4'(NR)) st_nxt = ROUND;
      ROUND:   if (cnt == 4'd0) st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      blk    <= '0;
      result <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
      for (int k = 0; k <= NR; k++) rk[k] <= '0;
    end else begin
      done <= 1'b0;
      case (st)
        IDLE: if (enable) begin
          busy <= 1'b1;
          if (hit) begin
            blk <= word ^ rk[NR];
            cnt <= 4'(NR - 1);
          end else begin
            rk[0] <= key[KEY_BW-1:TXT_BW];
            rk[1] <= key[TXT_BW-1:0];
            blk   <= word;
            cnt   <= 4'd2;
          end
        end
        KEXP: begin
          for (int k = 2; k <= NR; k++)
            if (k == int'(cnt)) rk[k] <= rk_new;
          // rk[14] is still combinational here, so the initial whitening uses rk_new.
          if (cnt == 4'(NR)) begin
            blk <= blk ^ rk_new;
            cnt <= 4'(NR - 1);
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ROUND: begin
          if (cnt == 4'd0) begin
            result <= rnd_out;
            done   <= 1'b1;
            busy   <= 1'b0;
          end else begin
            blk <= rnd_out;
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
